// File: rtl/branch_target_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_target_predictor_pkg
// Brief   : Shared sizing helpers and counter constants for the BTB predictor.
// Revision: 1.0
// ============================================================================
package branch_target_predictor_pkg;

    localparam int unsigned DEF_ENTRIES = 16;
    localparam int unsigned DEF_IMM_W   = 16;
    localparam int unsigned DEF_SHIFT   = 2;
    localparam int unsigned DEF_CNT_W   = 2;

    function automatic int unsigned btb_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Tag covers pc[31:IDX_W+2]; the two byte-offset bits never participate.
    function automatic int unsigned btb_tag_w(input int unsigned entries);
        return 30 - $clog2(entries);
    endfunction

    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    function automatic int unsigned cnt_weak_t(input int unsigned cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    function automatic int unsigned cnt_weak_nt(input int unsigned cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage : branch_target_predictor_pkg
`default_nettype wire

// File: rtl/branch_target_calc.sv
`default_nettype none
// ============================================================================
// Module  : branch_target_calc
// Brief   : PC + 4 + (sign-extended immediate << SHIFT), 32-bit wrap-around.
// Revision: 1.0
// ============================================================================
module branch_target_calc #(
    parameter int unsigned IMM_W = 16,
    parameter int unsigned SHIFT = 2
) (
    input  logic [31:0]      upd_pc,
    input  logic [IMM_W-1:0] upd_imm,
    output logic [31:0]      target
);

    logic [31:0] w_sext;

    if (IMM_W < 32) begin : g_sext
        assign w_sext = {{(32-IMM_W){upd_imm[IMM_W-1]}}, upd_imm};
    end else begin : g_trunc
        assign w_sext = upd_imm[31:0];
    end

    // Carry out of bit 31 is dropped so targets wrap around the address space.
    assign target = upd_pc + 32'd4 + (w_sext << SHIFT);

endmodule : branch_target_calc
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module  : branch_target_predictor
// Brief   : Direct-mapped BTB with saturating counters; combinational lookup.
// Revision: 1.0
// ============================================================================
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = DEF_ENTRIES,
    parameter int unsigned IMM_W   = DEF_IMM_W,
    parameter int unsigned SHIFT   = DEF_SHIFT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [IMM_W-1:0] upd_imm,
    input  logic             upd_taken,
    output logic [31:0]      upd_target
);

    localparam int unsigned IDX_W = btb_idx_w(ENTRIES);
    localparam int unsigned TAG_W = btb_tag_w(ENTRIES);

    localparam logic [CNT_W-1:0] c_CNT_MAX     = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] c_CNT_WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] c_CNT_WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    localparam entry_t c_ENTRY_RST = '{
        valid:  1'b0,
        tag:    '0,
        target: 32'd0,
        cnt:    c_CNT_WEAK_NT
    };

    entry_t table_q [ENTRIES];

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    entry_t           w_if_entry;

    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    entry_t           w_upd_entry;
    logic             w_upd_hit;
    entry_t           upd_entry_d;
    logic             w_upd_we;

    branch_target_calc #(
        .IMM_W (IMM_W),
        .SHIFT (SHIFT)
    ) u_calc (
        .upd_pc  (upd_pc),
        .upd_imm (upd_imm),
        .target  (upd_target)
    );

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign w_if_idx   = if_pc[IDX_W+1:2];
    assign w_if_tag   = if_pc[31:IDX_W+2];
    assign w_if_entry = table_q[w_if_idx];

    assign pred_hit    = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    assign pred_taken  = pred_hit && w_if_entry.cnt[CNT_W-1];
    assign pred_target = pred_taken ? w_if_entry.target : (if_pc + 32'd4);

    assign w_upd_idx   = upd_pc[IDX_W+1:2];
    assign w_upd_tag   = upd_pc[31:IDX_W+2];
    assign w_upd_entry = table_q[w_upd_idx];
    assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

    always_comb begin
        upd_entry_d = w_upd_entry;
        w_upd_we    = 1'b0;
        if (upd_valid) begin
            if (w_upd_hit) begin
                w_upd_we = 1'b1;
                if (upd_taken) begin
                    upd_entry_d.target = upd_target;
                    if (w_upd_entry.cnt != c_CNT_MAX) begin
                        upd_entry_d.cnt = w_upd_entry.cnt + c_CNT_ONE;
                    end
                end else if (w_upd_entry.cnt != '0) begin
                    upd_entry_d.cnt = w_upd_entry.cnt - c_CNT_ONE;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch evicts whatever aliases into this slot.
                w_upd_we           = 1'b1;
                upd_entry_d.valid  = 1'b1;
                upd_entry_d.tag    = w_upd_tag;
                upd_entry_d.target = upd_target;
                upd_entry_d.cnt    = c_CNT_WEAK_T;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= c_ENTRY_RST;
            end
        end else if (w_upd_we) begin
            table_q[w_upd_idx] <= upd_entry_d;
        end
    end

endmodule : branch_target_predictor
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// Table-driven directed bench for branch_target_predictor (16 entries, 2-bit counters).
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [15:0] upd_imm;
    logic        upd_taken;
    logic [31:0] upd_target;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_target_predictor #(
        .ENTRIES (16),
        .IMM_W   (16),
        .SHIFT   (2),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_imm     (upd_imm),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    typedef struct {
        string       name;
        logic [31:0] if_pc;
        logic        uv;
        logic [31:0] upc;
        logic [15:0] uimm;
        logic        ut;
        logic        exp_hit;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [31:0] exp_upd_target;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input logic [31:0] ipc, input logic uv,
                       input logic [31:0] upc, input logic [15:0] uimm, input logic ut,
                       input logic eh, input logic et, input logic [31:0] etgt,
                       input logic [31:0] eut);
        vec_t v;
        v.name = n; v.if_pc = ipc; v.uv = uv; v.upc = upc; v.uimm = uimm; v.ut = ut;
        v.exp_hit = eh; v.exp_taken = et; v.exp_target = etgt; v.exp_upd_target = eut;
        vq.push_back(v);
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", n, act, exp);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    // Inputs change at negedge; outputs sampled 1 time unit later, well before posedge.
    task automatic drive(input logic r, input logic [31:0] ipc, input logic uv,
                         input logic [31:0] upc, input logic [15:0] uimm, input logic ut);
        @(negedge clk);
        rst = r; if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_imm = uimm; upd_taken = ut;
        #1;
    endtask

    initial begin
        rst = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_imm = '0; upd_taken = 1'b0;

        //   name          if_pc         uv  upd_pc        imm      ut  hit tk  pred_target   upd_target
        add("reset_look", 32'h0040_0010, 0, 32'h0,         16'h0,    0, 0, 0, 32'h0040_0014, 32'h0000_0004);
        add("alloc",      32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 1, 0, 0, 32'h0040_0014, 32'h0040_0004);
        add("nt1",        32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 0, 1, 1, 32'h0040_0004, 32'h0040_0004);
        add("nt2",        32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 0, 1, 0, 32'h0040_0014, 32'h0040_0004);
        add("nt3_sat",    32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 0, 1, 0, 32'h0040_0014, 32'h0040_0004);
        add("t1",         32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 1, 1, 0, 32'h0040_0014, 32'h0040_0004);
        add("t2",         32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 1, 1, 0, 32'h0040_0014, 32'h0040_0004);
        add("t3",         32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 1, 1, 1, 32'h0040_0004, 32'h0040_0004);
        add("t4_sat",     32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 1, 1, 1, 32'h0040_0004, 32'h0040_0004);
        add("nt_from11",  32'h0040_0010, 1, 32'h0040_0010, 16'hFFFC, 0, 1, 1, 32'h0040_0004, 32'h0040_0004);
        add("cnt10",      32'h0040_0010, 0, 32'h0,         16'h0,    0, 1, 1, 32'h0040_0004, 32'h0000_0004);
        add("retarget",   32'h0040_0010, 1, 32'h0040_0010, 16'h0008, 1, 1, 1, 32'h0040_0004, 32'h0040_0034);
        add("retarget_rd",32'h0040_0010, 0, 32'h0,         16'h0,    0, 1, 1, 32'h0040_0034, 32'h0000_0004);
        add("nt_keep_tgt",32'h0040_0010, 1, 32'h0040_0010, 16'h0100, 0, 1, 1, 32'h0040_0034, 32'h0040_0414);
        add("keep_tgt_rd",32'h0040_0010, 0, 32'h0,         16'h0,    0, 1, 1, 32'h0040_0034, 32'h0000_0004);
        add("wrap_upd",   32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 16'h0001, 1, 0, 0, 32'h0000_0000, 32'h0000_0004);
        add("wrap_rd",    32'hFFFF_FFFC, 0, 32'h0,         16'h0,    0, 1, 1, 32'h0000_0004, 32'h0000_0004);
        add("alias_upd",  32'h0040_0050, 1, 32'h0040_0050, 16'hFFFC, 1, 0, 0, 32'h0040_0054, 32'h0040_0044);
        add("alias_old",  32'h0040_0010, 0, 32'h0,         16'h0,    0, 0, 0, 32'h0040_0014, 32'h0000_0004);
        add("alias_new",  32'h0040_0050, 0, 32'h0,         16'h0,    0, 1, 1, 32'h0040_0044, 32'h0000_0004);
        add("nt_unalloc", 32'h0040_0020, 1, 32'h0040_0020, 16'h0004, 0, 0, 0, 32'h0040_0024, 32'h0040_0034);
        add("unalloc_rd", 32'h0040_0020, 0, 32'h0,         16'h0,    0, 0, 0, 32'h0040_0024, 32'h0000_0004);
        add("nt_alias",   32'h0040_0050, 1, 32'h0040_0010, 16'h0000, 0, 1, 1, 32'h0040_0044, 32'h0040_0014);
        add("nt_alias_rd",32'h0040_0050, 0, 32'h0,         16'h0,    0, 1, 1, 32'h0040_0044, 32'h0000_0004);
        add("low_bits",   32'h0040_0053, 0, 32'h0,         16'h0,    0, 1, 1, 32'h0040_0044, 32'h0000_0004);

        drive(1'b1, 32'h0, 1'b0, 32'h0, 16'h0, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 16'h0, 1'b0);

        foreach (vq[i]) begin
            drive(1'b0, vq[i].if_pc, vq[i].uv, vq[i].upc, vq[i].uimm, vq[i].ut);
            chk1 ({vq[i].name, ".hit"},        pred_hit,    vq[i].exp_hit);
            chk1 ({vq[i].name, ".taken"},      pred_taken,  vq[i].exp_taken);
            chk32({vq[i].name, ".target"},     pred_target, vq[i].exp_target);
            chk32({vq[i].name, ".upd_target"}, upd_target,  vq[i].exp_upd_target);
        end

        // Reset coinciding with a taken update: update dropped, learned state gone.
        drive(1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080, 16'h0000, 1'b1);
        drive(1'b0, 32'h0040_0080, 1'b0, 32'h0, 16'h0, 1'b0);
        chk1 ("rst_upd.hit",      pred_hit,    1'b0);
        chk1 ("rst_upd.taken",    pred_taken,  1'b0);
        chk32("rst_upd.target",   pred_target, 32'h0040_0084);
        drive(1'b0, 32'h0040_0050, 1'b0, 32'h0, 16'h0, 1'b0);
        chk1 ("rst_flush.hit",    pred_hit,    1'b0);
        chk32("rst_flush.target", pred_target, 32'h0040_0054);
        drive(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 16'h0, 1'b0);
        chk1 ("rst_flush2.hit",   pred_hit,    1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_branch_target_predictor
`default_nettype wire

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Parametrised successor to the fixed shift-left-2 branch offset logic. Computes branch targets as sign-extended immediate shifted left by SHIFT, added to PC+4. Holds them in a direct-mapped branch target buffer with saturating taken/not-taken counters. The IF stage reads a prediction combinationally each cycle; the EX stage writes resolved branches back.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, minimum 2. IDX_W = log2(ENTRIES).
IMM_W, 16, branch immediate width.
SHIFT, 2, left shift applied to the sign-extended immediate.
CNT_W, 2, saturating counter width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
if_pc  in  32  fetch PC to look up
pred_hit  out  1  valid entry whose tag matches if_pc
pred_taken  out  1  pred_hit and counter MSB = 1
pred_target  out  32  stored target when pred_taken, else if_pc+4
upd_valid  in  1  resolved branch present this cycle
upd_pc  in  32  PC of resolved branch
upd_imm  in  IMM_W  raw branch immediate
upd_taken  in  1  actual branch outcome
upd_target  out  32  computed target for upd_pc/upd_imm, combinational, for the EX redirect path

Behaviour:
- Indexing: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Bits [1:0] are ignored.
- Entry contents: valid, tag, target[31:0], cnt[CNT_W-1:0].
- Target arithmetic: upd_target = upd_pc + 4 + (sign-extend upd_imm to 32, then << SHIFT).
  - 32-bit modulo sum; carry out is discarded, so addresses wrap.
- Lookup: purely combinational from if_pc and current table state; zero latency.
  - pred_hit = valid[idx] && tag[idx] == tag(if_pc).
- Update, applied at the clock edge when upd_valid = 1:
  - Hit on upd_pc:
    - taken: cnt saturates up to 2^CNT_W-1; target rewritten with upd_target.
    - not taken: cnt saturates down to 0; target unchanged.
  - Miss on upd_pc:
    - taken: allocate or overwrite the entry (alias eviction). Set valid=1, tag, target=upd_target, cnt=2^(CNT_W-1) (weakly taken).
    - not taken: no allocation; table unchanged.
- Same-cycle lookup and update on the same index: lookup returns pre-update contents (read-before-write). The new contents are visible the following cycle.
- Reset:
  - All valid=0; all cnt=2^(CNT_W-1)-1 (weakly not taken); tag and target cleared to 0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
  - rst has priority over upd_valid in the same cycle; the update is dropped.
  - Reset mid-operation discards all learned state.
- No handshake back-pressure: every upd_valid pulse is consumed in its cycle. Back-to-back updates to the same entry accumulate one counter step per cycle.

Decomposition:
- Shared package: ENTRIES/IDX_W derivation, counter constants (CNT_MAX, CNT_WEAK_T, CNT_WEAK_NT), and the entry struct/typedef for {valid, tag, target, cnt}.
- One sub-module: branch_target_calc (in upd_pc, upd_imm; out target). This is the generalised sign-extend, shift-by-SHIFT, PC+4 adder, reusable by the EX stage. The counter update logic stays inline.

Test Plan:
- Reset, then if_pc=0x0040_0010 -> pred_hit=0, pred_taken=0, pred_target=0x0040_0014.
- upd_valid, upd_pc=0x0040_0010, upd_imm=0xFFFC, upd_taken=1 -> upd_target=0x0040_0004. Next cycle, lookup of 0x0040_0010 -> hit=1, taken=1 (cnt=10), target=0x0040_0004.
- Counter saturation on the same PC:
  - two not-taken updates -> cnt 00, pred_taken=0, pred_target=0x0040_0014.
  - a third not-taken update -> cnt stays 00.
  - three taken updates -> cnt reaches 11 and stays there.
- Wrap: upd_pc=0xFFFF_FFFC, upd_imm=0x0001, taken -> upd_target=0x0000_0004. A later lookup hits with that target.
- Alias: allocate 0x0040_0010, then a taken update on 0x0040_0050 (same index 4) -> lookup of 0x0040_0010 misses, lookup of 0x0040_0050 hits. A not-taken update on an unallocated PC leaves the table unchanged.
- Simultaneous and reset cases:
  - update and lookup on the same PC in one cycle -> old value that cycle, new value the next cycle.
  - rst=1 together with upd_valid=1 -> the entry is not allocated, and pred_hit=0 afterwards.
